// File: rtl/time_entry.sv
// time_entry: operator time-entry stage feeding the microwave countdown timer.
//   Turns raw push-button levels into an edited MM:SS value held as four BCD
//   digits. Supports per-digit up/down with auto-repeat, cursor selection,
//   +30 s and clear. All edits are frozen while lock is high.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   btn_up     raw level, increments the selected digit (auto-repeats)
//   btn_down   raw level, decrements the selected digit (auto-repeats)
//   btn_next   raw level, advances the cursor
//   btn_add30  raw level, adds 30 s to the whole value (saturates at 99:59)
//   btn_clear  raw level, zeroes the value and the cursor
//   lock       high while the timer runs or is paused; edits ignored
//   min        binary minutes 0..99
//   sec        binary seconds 0..59
//   cursor     0 = sec units, 1 = sec tens, 2 = min units, 3 = min tens
//   blink      flash strobe for the selected digit (0 while locked)
//   zero       high when the value is 00:00

module time_entry #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int BLINK_HALF    = 25_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    input  logic       btn_add30,
    input  logic       btn_clear,
    input  logic       lock,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic [1:0] cursor,
    output logic       blink,
    output logic       zero
);

    localparam logic [26:0] HOLD_C   = 27'(HOLD_CYCLES);
    localparam logic [26:0] RELOAD_C = 27'(HOLD_CYCLES - REPEAT_CYCLES);
    localparam logic [26:0] BLINK_C  = 27'(BLINK_HALF - 1);

    logic [3:0]  su, st, mu, mt;
    logic [3:0]  su_n, st_n, mu_n, mt_n;
    logic [1:0]  cursor_n;
    logic        p_up, p_down, p_next, p_add30, p_clear;
    logic [26:0] rc;
    logic        rep_arm;
    logic [26:0] bc;

    logic e_up, e_down, e_next, e_add30, e_clear;
    logic one_held, rc_hit, rep_step, do_inc, do_dec;

    assign e_up    = btn_up    & ~p_up;
    assign e_down  = btn_down  & ~p_down;
    assign e_next  = btn_next  & ~p_next;
    assign e_add30 = btn_add30 & ~p_add30;
    assign e_clear = btn_clear & ~p_clear;

    assign one_held = btn_up ^ btn_down;
    assign rc_hit   = (rc + 27'd1) == HOLD_C;
    // Repeat only continues a hold that began with a real edge, so a button
    // still held across reset or unlock never starts repeating on its own.
    assign rep_step = rep_arm & one_held & rc_hit & ~e_up & ~e_down;
    assign do_inc   = e_up   | (rep_step & btn_up);
    assign do_dec   = e_down | (rep_step & btn_down);

    // Wrapping step of a single digit; no carry or borrow into neighbours.
    function automatic logic [3:0] digit_step(input logic [3:0] d,
                                              input logic [3:0] maxv,
                                              input logic       up);
        if (up) return (d == maxv) ? 4'd0 : d + 4'd1;
        else    return (d == 4'd0) ? maxv : d - 4'd1;
    endfunction

    always_comb begin
        su_n     = su;
        st_n     = st;
        mu_n     = mu;
        mt_n     = mt;
        cursor_n = cursor;
        if (!lock) begin
            if (e_clear) begin
                su_n     = 4'd0;
                st_n     = 4'd0;
                mu_n     = 4'd0;
                mt_n     = 4'd0;
                cursor_n = 2'd0;
            end else if (e_add30) begin
                // +30 s touches only st and carries into minutes when st >= 3;
                // the only overflow case is 99:30..99:59.
                if (st >= 4'd3) begin
                    if (mt == 4'd9 && mu == 4'd9) begin
                        su_n = 4'd9;
                        st_n = 4'd5;
                    end else begin
                        st_n = st - 4'd3;
                        if (mu == 4'd9) begin
                            mu_n = 4'd0;
                            mt_n = mt + 4'd1;
                        end else begin
                            mu_n = mu + 4'd1;
                        end
                    end
                end else begin
                    st_n = st + 4'd3;
                end
            end else if (do_inc ^ do_dec) begin
                case (cursor)
                    2'd0:    su_n = digit_step(su, 4'd9, do_inc);
                    2'd1:    st_n = digit_step(st, 4'd5, do_inc);
                    2'd2:    mu_n = digit_step(mu, 4'd9, do_inc);
                    default: mt_n = digit_step(mt, 4'd9, do_inc);
                endcase
            end
            // Clear homes the cursor and takes precedence over next.
            if (e_next && !e_clear) cursor_n = cursor + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            su      <= 4'd0;
            st      <= 4'd0;
            mu      <= 4'd0;
            mt      <= 4'd0;
            cursor  <= 2'd0;
            blink   <= 1'b0;
            bc      <= 27'd0;
            rc      <= 27'd0;
            rep_arm <= 1'b0;
            // Load history from the live levels so a held button is not
            // seen as a fresh press when reset releases.
            p_up    <= btn_up;
            p_down  <= btn_down;
            p_next  <= btn_next;
            p_add30 <= btn_add30;
            p_clear <= btn_clear;
        end else begin
            su      <= su_n;
            st      <= st_n;
            mu      <= mu_n;
            mt      <= mt_n;
            cursor  <= cursor_n;
            p_up    <= btn_up;
            p_down  <= btn_down;
            p_next  <= btn_next;
            p_add30 <= btn_add30;
            p_clear <= btn_clear;

            if (lock || !one_held || e_up || e_down) begin
                rc      <= 27'd0;
                rep_arm <= !lock && one_held && (e_up || e_down);
            end else if (rep_arm) begin
                rc <= rc_hit ? RELOAD_C : rc + 27'd1;
            end

            if (lock) begin
                blink <= 1'b0;
                bc    <= 27'd0;
            end else if (bc == BLINK_C) begin
                blink <= ~blink;
                bc    <= 27'd0;
            end else begin
                bc <= bc + 27'd1;
            end
        end
    end

    assign min  = 7'(mt) * 7'd10 + 7'(mu);
    assign sec  = 7'(st) * 7'd10 + 7'(su);
    assign zero = (su == 4'd0) && (st == 4'd0) && (mu == 4'd0) && (mt == 4'd0);

endmodule

// File: tb/tb_time_entry.sv
// tb_time_entry: directed self-checking bench for time_entry.
//   Small timing parameters (HOLD 4, REPEAT 2, BLINK_HALF 8) keep the
//   auto-repeat and blink scenarios short.

module tb_time_entry;

    logic       clock = 1'b0;
    logic       reset;
    logic       btn_up, btn_down, btn_next, btn_add30, btn_clear, lock;
    logic [6:0] min, sec;
    logic [1:0] cursor;
    logic       blink, zero;

    int checks = 0;
    int errors = 0;

    time_entry #(
        .HOLD_CYCLES  (4),
        .REPEAT_CYCLES(2),
        .BLINK_HALF   (8)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_next (btn_next),
        .btn_add30(btn_add30),
        .btn_clear(btn_clear),
        .lock     (lock),
        .min      (min),
        .sec      (sec),
        .cursor   (cursor),
        .blink    (blink),
        .zero     (zero)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic press_up();    btn_up = 1;    tick(); btn_up = 0;    tick(); endtask
    task automatic press_down();  btn_down = 1;  tick(); btn_down = 0;  tick(); endtask
    task automatic press_next();  btn_next = 1;  tick(); btn_next = 0;  tick(); endtask
    task automatic press_add30(); btn_add30 = 1; tick(); btn_add30 = 0; tick(); endtask
    task automatic press_clear(); btn_clear = 1; tick(); btn_clear = 0; tick(); endtask

    task automatic test_reset();
        reset = 1; btn_up = 0; btn_down = 0; btn_next = 0;
        btn_add30 = 0; btn_clear = 0; lock = 0;
        tick(2);
        reset = 0;
        checks++; if (min !== 7'd0) begin errors++; $display("FAIL reset_min got %0d exp 0", min); end
        checks++; if (sec !== 7'd0) begin errors++; $display("FAIL reset_sec got %0d exp 0", sec); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL reset_cursor got %0d exp 0", cursor); end
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL reset_blink got %b exp 0", blink); end
        tick(7);
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_before_half got %b exp 0", blink); end
        tick();
        checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_at_half got %b exp 1", blink); end
    endtask

    task automatic test_digit_edit();
        for (int i = 0; i < 3; i++) press_up();
        checks++; if (sec !== 7'd3 || min !== 7'd0) begin errors++; $display("FAIL up3 got %0d:%0d exp 0:3", min, sec); end
        press_next();
        for (int i = 0; i < 7; i++) press_up();
        checks++; if (sec !== 7'd13) begin errors++; $display("FAIL st_wrap_sec got %0d exp 13", sec); end
        checks++; if (min !== 7'd0) begin errors++; $display("FAIL st_wrap_min got %0d exp 0", min); end
        checks++; if (cursor !== 2'd1) begin errors++; $display("FAIL st_wrap_cursor got %0d exp 1", cursor); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL nonzero_flag got %b exp 0", zero); end
    endtask

    task automatic test_add30();
        press_clear();
        checks++; if (min !== 7'd0 || sec !== 7'd0 || cursor !== 2'd0) begin
            errors++; $display("FAIL clear got %0d:%0d c%0d exp 0:0 c0", min, sec, cursor); end
        // build 99:45 : mt down (9->... 0->9), su +5, st +4, mu down (0->9)
        press_next(); press_next(); press_next();
        press_down();
        press_next();
        for (int i = 0; i < 5; i++) press_up();
        press_next();
        for (int i = 0; i < 4; i++) press_up();
        press_next();
        press_down();
        checks++; if (min !== 7'd99 || sec !== 7'd45) begin errors++; $display("FAIL preload_9945 got %0d:%0d exp 99:45", min, sec); end
        press_add30();
        checks++; if (min !== 7'd99 || sec !== 7'd59) begin errors++; $display("FAIL add30_sat got %0d:%0d exp 99:59", min, sec); end
        checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL add30_cursor got %0d exp 2", cursor); end
        press_clear();
        for (int i = 0; i < 5; i++) press_up();
        press_next();
        for (int i = 0; i < 4; i++) press_up();
        press_next();
        press_up();
        checks++; if (min !== 7'd1 || sec !== 7'd45) begin errors++; $display("FAIL preload_0145 got %0d:%0d exp 1:45", min, sec); end
        btn_add30 = 1;
        tick();
        checks++; if (min !== 7'd2 || sec !== 7'd15) begin errors++; $display("FAIL add30_carry got %0d:%0d exp 2:15", min, sec); end
        btn_add30 = 0;
        tick();
        checks++; if (min !== 7'd2 || sec !== 7'd15) begin errors++; $display("FAIL add30_single got %0d:%0d exp 2:15", min, sec); end
    endtask

    task automatic test_repeat();
        int exp_mu[10] = '{9, 9, 9, 9, 8, 8, 7, 7, 6, 6};
        press_clear();
        press_next(); press_next();
        btn_down = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (min !== 7'(exp_mu[k]) || sec !== 7'd0) begin
                errors++; $display("FAIL repeat_cycle%0d got %0d:%0d exp %0d:0", k, min, sec, exp_mu[k]);
            end
        end
        btn_down = 0;
        tick(8);
        checks++; if (min !== 7'd6) begin errors++; $display("FAIL repeat_release got %0d exp 6", min); end
    endtask

    task automatic test_lock();
        lock = 1;
        tick();
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL lock_blink got %b exp 0", blink); end
        press_up();
        press_add30();
        press_clear();
        checks++; if (min !== 7'd6 || sec !== 7'd0) begin errors++; $display("FAIL lock_value got %0d:%0d exp 6:0", min, sec); end
        checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL lock_cursor got %0d exp 2", cursor); end
        btn_next = 1;
        tick(9);
        checks++; if (blink !== 1'b0) begin errors++; $display("FAIL lock_blink_held got %b exp 0", blink); end
        lock = 0;
        tick(2);
        btn_next = 0;
        tick();
        checks++; if (cursor !== 2'd2) begin errors++; $display("FAIL unlock_next got %0d exp 2", cursor); end
        checks++; if (min !== 7'd6 || sec !== 7'd0) begin errors++; $display("FAIL unlock_value got %0d:%0d exp 6:0", min, sec); end
    endtask

    task automatic test_simultaneous();
        btn_up = 1; btn_down = 1; btn_next = 1;
        tick();
        checks++; if (min !== 7'd6 || sec !== 7'd0) begin errors++; $display("FAIL updown_value got %0d:%0d exp 6:0", min, sec); end
        checks++; if (cursor !== 2'd3) begin errors++; $display("FAIL updown_cursor got %0d exp 3", cursor); end
        btn_up = 0; btn_down = 0; btn_next = 0;
        tick();
        btn_clear = 1; btn_add30 = 1;
        tick();
        checks++; if (min !== 7'd0 || sec !== 7'd0) begin errors++; $display("FAIL clear_add30 got %0d:%0d exp 0:0", min, sec); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL clear_add30_zero got %b exp 1", zero); end
        checks++; if (cursor !== 2'd0) begin errors++; $display("FAIL clear_cursor got %0d exp 0", cursor); end
        btn_clear = 0; btn_add30 = 0;
        tick();
    endtask

    task automatic test_reset_mid_repeat();
        btn_up = 1;
        tick(6);
        checks++; if (sec !== 7'd2) begin errors++; $display("FAIL pre_reset_repeat got %0d exp 2", sec); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if (min !== 7'd0 || sec !== 7'd0) begin errors++; $display("FAIL midrep_reset got %0d:%0d exp 0:0", min, sec); end
        checks++; if (cursor !== 2'd0 || blink !== 1'b0) begin errors++; $display("FAIL midrep_reset_cb got c%0d b%b exp c0 b0", cursor, blink); end
        tick(10);
        checks++; if (sec !== 7'd0) begin errors++; $display("FAIL held_after_reset got %0d exp 0", sec); end
        btn_up = 0;
        tick();
        btn_up = 1;
        tick();
        checks++; if (sec !== 7'd1) begin errors++; $display("FAIL repress_after_reset got %0d exp 1", sec); end
        btn_up = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_digit_edit();
        test_add30();
        test_repeat();
        test_lock();
        test_simultaneous();
        test_reset_mid_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
